// File: rtl/piso_pkg.sv
// ============================================================================
// Module      : piso_pkg
// Description : Shared state encoding and width helper for the PISO serializer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package piso_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int count_width(input int dw);
        return (dw > 2) ? $clog2(dw) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso.sv
// ============================================================================
// Module      : piso
// Description : Parallel-in serial-out shifter with valid/ready on both sides
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  serial_out,
    output logic                  serial_valid,
    input  logic                  serial_ready,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int                 c_CNT_W      = count_width(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_COUNT = c_CNT_W'(DATA_WIDTH - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_CNT_W-1:0]      w_count_next;
    logic                    w_shifting;
    logic                    w_last;
    logic                    w_advance;
    logic                    w_accept;
    logic                    w_head_bit;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = w_shifting && (r_count == c_LAST_COUNT);
    assign w_advance  = w_shifting && serial_ready;

    // Ready during the last bit lets a new word chain on with no idle gap.
    assign load_ready = !reset && (!w_shifting || (w_last && serial_ready));
    assign w_accept   = load_valid && load_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head_bit = r_shift[DATA_WIDTH-1];
            assign w_shifted  = {r_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head_bit = r_shift[0];
            assign w_shifted  = {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_SHIFT;
                    w_shift_next = parallel_in;
                    w_count_next = '0;
                end
            end
            ST_SHIFT: begin
                if (w_advance) begin
                    if (w_last) begin
                        if (w_accept) begin
                            w_shift_next = parallel_in;
                            w_count_next = '0;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_shift_next = '0;
                            w_count_next = '0;
                        end
                    end else begin
                        w_shift_next = w_shifted;
                        w_count_next = r_count + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_shift_next = '0;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_count <= w_count_next;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign serial_valid = w_shifting;
    assign serial_out   = w_shifting && w_head_bit;
    assign busy         = w_shifting;
    assign frame_start  = w_shifting && (r_count == '0);
    assign frame_done   = w_last;

endmodule

`default_nettype wire

// File: tb/tb_piso.sv
// ============================================================================
// Module      : tb_piso
// Description : Self-checking bench for piso (both bit orders, width 16)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic [DW-1:0] parallel_in;
    logic          load_valid;
    logic          serial_ready;

    logic m_ready, m_out, m_valid, m_start, m_done, m_busy;
    logic l_ready, l_out, l_valid, l_start, l_done, l_busy;

    piso #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .parallel_in(parallel_in),
        .load_valid(load_valid), .load_ready(m_ready),
        .serial_out(m_out), .serial_valid(m_valid), .serial_ready(serial_ready),
        .frame_start(m_start), .frame_done(m_done), .busy(m_busy)
    );

    piso #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .parallel_in(parallel_in),
        .load_valid(load_valid), .load_ready(l_ready),
        .serial_out(l_out), .serial_valid(l_valid), .serial_ready(serial_ready),
        .frame_start(l_start), .frame_done(l_done), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid_cyc;
    int n_starts;

    // Reference: pending bits in transmit order; a frame is DW bits queued.
    bit q_msb[$];
    bit q_lsb[$];

    typedef struct {
        logic          lv;
        logic [DW-1:0] din;
        logic          sr;
        logic [5:0]    exp_m;
        logic [5:0]    exp_l;
    } vec_t;
    vec_t tbl[18];

    function automatic logic [5:0] outs_m();
        return {m_valid, m_out, m_start, m_done, m_busy, m_ready};
    endfunction

    function automatic logic [5:0] outs_l();
        return {l_valid, l_out, l_start, l_done, l_busy, l_ready};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b (valid,out,start,done,busy,ready)",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [DW-1:0] din, input logic sr);
        load_valid   = lv;
        parallel_in  = din;
        serial_ready = sr;
    endtask

    // Compare both DUTs against the queue model, then advance the model.
    task automatic model_cycle();
        int         sz;
        logic       e_ready;
        logic [5:0] e_m;
        logic [5:0] e_l;
        sz      = q_msb.size();
        e_ready = (sz == 0) || ((sz == 1) && serial_ready);
        e_m = {sz != 0, (sz != 0) ? logic'(q_msb[0]) : 1'b0, sz == DW, sz == 1, sz != 0, e_ready};
        e_l = {sz != 0, (sz != 0) ? logic'(q_lsb[0]) : 1'b0, sz == DW, sz == 1, sz != 0, e_ready};
        check("model_msb", outs_m(), e_m);
        check("model_lsb", outs_l(), e_l);
        if (m_valid) n_valid_cyc++;
        if (m_start) n_starts++;
        if ((sz != 0) && serial_ready) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
        end
        if (load_valid && e_ready) begin
            for (int i = DW - 1; i >= 0; i--) q_msb.push_back(parallel_in[i]);
            for (int i = 0; i < DW; i++)      q_lsb.push_back(parallel_in[i]);
        end
    endtask

    task automatic step(input logic lv, input logic [DW-1:0] din, input logic sr);
        drive(lv, din, sr);
        #4;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] pat_m;
    logic [DW-1:0] pat_l;

    initial begin
        drive(1'b0, '0, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_msb", outs_m(), 6'b000000);
        check("reset_lsb", outs_l(), 6'b000000);
        @(posedge clk);
        #1;
        check("reset_held", outs_m(), 6'b000000);
        reset = 1'b0;

        // A5C3 in both bit orders, against literal bit strings.
        pat_m = 16'b1010010111000011;
        pat_l = 16'b1100001110100101;
        for (int i = 0; i < 18; i++) begin
            tbl[i].lv  = (i == 0);
            tbl[i].din = (i == 0) ? 16'hA5C3 : 16'h0000;
            tbl[i].sr  = 1'b1;
            if (i == 0 || i == 17) begin
                tbl[i].exp_m = 6'b000001;
                tbl[i].exp_l = 6'b000001;
            end else begin
                tbl[i].exp_m = {1'b1, pat_m[16-i], i == 1, i == 16, 1'b1, i == 16};
                tbl[i].exp_l = {1'b1, pat_l[16-i], i == 1, i == 16, 1'b1, i == 16};
            end
        end
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].lv, tbl[i].din, tbl[i].sr);
            #4;
            check("tbl_msb", outs_m(), tbl[i].exp_m);
            check("tbl_lsb", outs_l(), tbl[i].exp_l);
            model_cycle();
            @(posedge clk);
            #1;
        end

        // Back-to-back frames: FFFF then 0000 held on load_valid.
        n_valid_cyc = 0;
        n_starts    = 0;
        step(1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b0, 16'h0000, 1'b1);
        check_int("b2b_valid_bits", n_valid_cyc, 32);
        check_int("b2b_frame_starts", n_starts, 2);

        // Stall three cycles while bit 5 is presented.
        n_valid_cyc = 0;
        step(1'b1, 16'hA5C3, 1'b1);
        for (int i = 0; i < 4; i++)  step(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++)  step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b1);
        check_int("stall_frame_len", n_valid_cyc, 19);

        // Offer 1234 mid-frame; it must be ignored.
        n_starts = 0;
        step(1'b1, 16'hA5C3, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
        check_int("ignored_load_starts", n_starts, 1);

        // Reset asserted between edges while bit 10 is presented.
        step(1'b1, 16'hA5C3, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 16'h0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_msb", outs_m(), 6'b000000);
        check("async_rst_lsb", outs_l(), 6'b000000);
        q_msb.delete();
        q_lsb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
